// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data memory controller.
// Holds the access-size encodings, the controller state enum and the
// store byte-lane mask helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  // Byte-enable mask for a store of the given size at the given lane.
  function automatic logic [3:0] lane_mask(input size_e sz, input logic [1:0] lane);
    logic [3:0] m;
    m = 4'b0000;
    case (sz)
      SZ_BYTE: m = 4'b0001 << lane;
      SZ_HALF: m = 4'b0011 << lane;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH_WORDS x 32 storage, synchronous byte-enabled write and
// synchronous read through a shared word index. Contents are never reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           i_we,
  input  logic [3:0]                     i_be,
  input  logic                           i_re,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
  input  logic [31:0]                    i_wdata,
  output logic [31:0]                    o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // Byte-lane write and registered read; only one of the two is ever
  // requested for a given access.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_re) o_rdata <= r_mem[i_idx];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: MIPS data memory controller with a valid/ready request
// port, byte/half/word access, sign/zero extension, WAIT_STATES extra
// cycles of latency and an error response for illegal accesses.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (misaligned half/word
// accesses report an error instead of being forced to alignment).
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int                    DEPTH_WORDS = 1024,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  write_en,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [31:0]           data_write,
  output logic                  resp_valid,
  output logic [31:0]           data_out,
  output logic                  error
);

  localparam int                  IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] LIMIT    = (ADDR_WIDTH+1)'(DEPTH_WORDS * 4);
  localparam logic [3:0]          WS_M1    = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam state_e              ACC_NEXT = (WAIT_STATES > 0) ? WAIT : RESP;

  state_e                r_state, w_next;
  logic [3:0]            r_cnt;
  logic                  w_accept, w_commit;

  logic [ADDR_WIDTH-1:0] r_addr;
  size_e                 r_size;
  logic                  r_sext, r_we;
  logic [31:0]           r_wdata;

  logic [ADDR_WIDTH-1:0] w_addr, w_off;
  size_e                 w_size;
  logic                  w_sext, w_we;
  logic [31:0]           w_wdata;
  logic [1:0]            w_lane_raw, w_lane;
  logic                  w_in_range, w_mis, w_err;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_arr_we, w_arr_re;
  logic [3:0]            w_be;
  logic [31:0]           w_arr_wdata, w_rdata;

  logic [1:0]            r_rsp_lane;
  size_e                 r_rsp_size;
  logic                  r_rsp_sext;
  logic                  r_rsp_zero;
  logic                  r_err;

  // Shift the addressed byte/half down to bit 0 and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] q, input logic [1:0] lane,
                                              input size_e sz, input logic sext);
    logic [31:0] s;
    logic [31:0] r;
    s = q >> {lane, 3'b000};
    case (sz)
      SZ_BYTE: r = {{24{sext & s[7]}}, s[7:0]};
      SZ_HALF: r = {{16{sext & s[15]}}, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  // State register: reset returns to IDLE and drops any pending access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state and handshake decode.
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b1;
    resp_valid = 1'b0;
    w_accept   = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          w_next   = ACC_NEXT;
        end
      end
      WAIT: begin
        req_ready = 1'b0;
        if (r_cnt == 4'd0) w_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
          w_next   = ACC_NEXT;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Wait-state counter: loaded on acceptance, counts down while waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 4'd0;
    end else if (w_accept && (ACC_NEXT == WAIT)) begin
      r_cnt <= WS_M1;
    end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Request capture for accesses that complete after wait states.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr  <= address;
      r_size  <= size_e'(size);
      r_sext  <= sign_ext;
      r_we    <= write_en;
      r_wdata <= data_write;
    end
  end

  // The access commits on the edge entering RESP. Without wait states that
  // is the acceptance edge itself, so the live request is used directly.
  always_comb begin
    w_addr     = (r_state == WAIT) ? r_addr  : address;
    w_size     = (r_state == WAIT) ? r_size  : size_e'(size);
    w_sext     = (r_state == WAIT) ? r_sext  : sign_ext;
    w_we       = (r_state == WAIT) ? r_we    : write_en;
    w_wdata    = (r_state == WAIT) ? r_wdata : data_write;
    w_off      = w_addr - BASE_ADDR;
    w_in_range = ({1'b0, w_off} < LIMIT);
    w_lane_raw = w_off[1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
    w_mis  = ((w_size == SZ_HALF) && w_lane_raw[0]) ||
             ((w_size == SZ_WORD) && (w_lane_raw != 2'b00));
    w_lane = w_lane_raw;
`else
    w_mis  = 1'b0;
    if (w_size == SZ_HALF)      w_lane = {w_lane_raw[1], 1'b0};
    else if (w_size == SZ_WORD) w_lane = 2'b00;
    else                        w_lane = w_lane_raw;
`endif
    w_err       = (w_size == SZ_ILL) || !w_in_range || w_mis;
    w_idx       = w_off[IDX_W+1:2];
    w_commit    = (w_next == RESP);
    w_be        = lane_mask(w_size, w_lane);
    w_arr_wdata = (w_size == SZ_BYTE) ? {4{w_wdata[7:0]}} :
                  (w_size == SZ_HALF) ? {2{w_wdata[15:0]}} : w_wdata;
    // Gate writes with reset so a request seen while in reset cannot land.
    w_arr_we    = w_commit && w_we && !w_err && reset;
    w_arr_re    = w_commit && !w_we && !w_err;
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .i_we    (w_arr_we),
    .i_be    (w_be),
    .i_re    (w_arr_re),
    .i_idx   (w_idx),
    .i_wdata (w_arr_wdata),
    .o_rdata (w_rdata)
  );

  // Response status: error flag and the force-to-zero flag for stores/errors.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err      <= 1'b0;
      r_rsp_zero <= 1'b1;
    end else if (w_commit) begin
      r_err      <= w_err;
      r_rsp_zero <= w_err || w_we;
    end
  end

  // Response steering fields, held alongside the registered read data.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_rsp_lane <= w_lane;
      r_rsp_size <= w_size;
      r_rsp_sext <= w_sext;
    end
  end

  assign error    = r_err;
  assign data_out = r_rsp_zero ? 32'd0 : load_extend(w_rdata, r_rsp_lane, r_rsp_size, r_rsp_sext);

endmodule
